// File: rtl/multiple_fp_pkg.sv
// Shared types and helpers for the multiple_fp_pipe floating-point multiplier.
package multiple_fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  localparam int FP_MAX_W = 64;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN, right-aligned in FP_MAX_W bits; callers slice to W.
  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
    r[man_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/multiple_fp_round.sv
// S3 normalise / round / pack. MULTIPLE_FP_PIPE_RNE_EN selects round-to-nearest-even,
// otherwise the significand is truncated.
module multiple_fp_round
  import multiple_fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W   = 1 + EXP_W + MAN_W,
  localparam int SW  = MAN_W + 1,
  localparam int PW  = 2 * SW,
  localparam int EW2 = EXP_W + 2
) (
  input  logic                  sign,
  input  fp_class_t             cls,
  input  logic signed [EW2-1:0] e,
  input  logic [PW-1:0]         prod,
  output logic [W-1:0]          res
);

  localparam logic [FP_MAX_W-1:0] QNAN_FULL = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];
  localparam logic signed [EW2-1:0] E_ZERO = '0;
  localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
  localparam logic signed [EW2-1:0] E_MAX  = EW2'({EXP_W{1'b1}});

  logic [PW-1:0]         norm;
  logic [SW-1:0]         sig;
  logic [MAN_W-1:0]      frac;
  logic signed [EW2-1:0] e_n, e_r;

  // Product lies in [1,4): left-align so the hidden bit is always norm[PW-1].
  assign norm = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
  assign e_n  = e + (prod[PW-1] ? E_ONE : E_ZERO);
  assign sig  = norm[PW-1 -: SW];

`ifdef MULTIPLE_FP_PIPE_RNE_EN
  logic        guard, sticky, rnd_up;
  logic [SW:0] sum;
  assign guard  = norm[PW-1-SW];
  assign sticky = |norm[PW-2-SW:0];
  assign rnd_up = guard & (sticky | sig[0]);
  assign sum    = {1'b0, sig} + {{SW{1'b0}}, rnd_up};
  // Carry out means sig was all ones: result is 1.000.. with exponent + 1.
  assign frac   = sum[SW] ? sum[SW-1:1] : sum[MAN_W-1:0];
  assign e_r    = e_n + (sum[SW] ? E_ONE : E_ZERO);
`else
  logic unused_trunc;
  assign unused_trunc = ^{norm[PW-1-SW:0], sig[MAN_W]};
  assign frac = sig[MAN_W-1:0];
  assign e_r  = e_n;
`endif

  always_comb begin
    res = {sign, {(W-1){1'b0}}};
    case (cls)
      FP_NAN:  res = QNAN;
      FP_INF:  res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: res = {sign, {(W-1){1'b0}}};
      default: begin
        if (e_r >= E_MAX)      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e_r > E_ZERO) res = {sign, e_r[EXP_W-1:0], frac};
      end
    endcase
  end

endmodule

// File: rtl/multiple_fp_pipe.sv
// Three-stage valid/ready floating-point multiplier with sideband tag.
// Build option MULTIPLE_FP_PIPE_RNE_EN: round-to-nearest-even instead of truncation.
module multiple_fp_pipe
  import multiple_fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = 3;
  localparam int SW     = MAN_W + 1;
  localparam int PW     = 2 * SW;
  localparam int EW2    = EXP_W + 2;
  localparam logic signed [EW2-1:0] BIAS_E = EW2'(fp_bias(EXP_W));

  function automatic fp_class_t classify(input logic [W-1:0] x);
    if (x[W-2 -: EXP_W] == '0)           return FP_ZERO;
    if (x[W-2 -: EXP_W] == '1)           return (x[MAN_W-1:0] == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  logic              adv;
  logic [STAGES:1]   vld_pipe;

  fp_class_t             cls_a, cls_b, cls_d;
  logic signed [EW2-1:0] e_d;

  logic                  s1_sign;
  fp_class_t             s1_cls;
  logic signed [EW2-1:0] s1_e;
  logic [SW-1:0]         s1_ma, s1_mb;
  logic [TAG_W-1:0]      s1_tag;

  logic                  s2_sign;
  fp_class_t             s2_cls;
  logic signed [EW2-1:0] s2_e;
  logic [PW-1:0]         s2_prod;
  logic [TAG_W-1:0]      s2_tag;

  logic [W-1:0]          rnd_res;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !rst;
  assign out_valid = vld_pipe[STAGES];

  assign cls_a = classify(in_a);
  assign cls_b = classify(in_b);
  assign e_d   = $signed({2'b00, in_a[W-2 -: EXP_W]}) + $signed({2'b00, in_b[W-2 -: EXP_W]}) - BIAS_E;

  // Resolve the result class up front so later stages only carry one class.
  always_comb begin
    cls_d = FP_NORM;
    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_ZERO && cls_b == FP_INF) || (cls_a == FP_INF && cls_b == FP_ZERO))
      cls_d = FP_NAN;
    else if (cls_a == FP_INF || cls_b == FP_INF)
      cls_d = FP_INF;
    else if (cls_a == FP_ZERO || cls_b == FP_ZERO)
      cls_d = FP_ZERO;
  end

  always_ff @(posedge clk) begin
    if (rst)      vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Datapath registers carry no reset; validity is tracked by vld_pipe.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= in_a[W-1] ^ in_b[W-1];
      s1_cls  <= cls_d;
      s1_e    <= e_d;
      s1_ma   <= {1'b1, in_a[MAN_W-1:0]};
      s1_mb   <= {1'b1, in_b[MAN_W-1:0]};
      s1_tag  <= in_tag;
      s2_sign <= s1_sign;
      s2_cls  <= s1_cls;
      s2_e    <= s1_e;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_tag  <= s1_tag;
    end
  end

  multiple_fp_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign (s2_sign),
    .cls  (s2_cls),
    .e    (s2_e),
    .prod (s2_prod),
    .res  (rnd_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_tag  <= '0;
    end else if (adv) begin
      out_data <= rnd_res;
      out_tag  <= s2_tag;
    end
  end

endmodule

// File: tb/tb_multiple_fp_pipe.sv
// Self-checking bench for multiple_fp_pipe (default parameters), arithmetic reference model.
module tb_multiple_fp_pipe;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

`ifdef MULTIPLE_FP_PIPE_RNE_EN
  localparam logic [31:0] RND_EXP = 32'h3FC00003;
`else
  localparam logic [31:0] RND_EXP = 32'h3FC00002;
`endif

  multiple_fp_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Exact integer product, rounded by comparing the discarded remainder to half an ulp.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, n, sh, ex;
    bit s, za, zb, ia, ib, na, nb;
    longint unsigned p, q;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);   zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (za && ib) || (ia && zb)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'h0};
    if (za || zb) return {s, 31'h0};
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    n = 0;
    for (int i = 0; i < 64; i++) if (p[i]) n = i + 1;
    sh = n - 24;
    q  = p >> sh;
    ex = ea + eb + n - 174;
`ifdef MULTIPLE_FP_PIPE_RNE_EN
    begin
      longint unsigned rem, half;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin q = q >> 1; ex = ex + 1; end
    end
`endif
    if (ex >= 255) return {s, 8'hFF, 23'h0};
    if (ex <= 0)   return {s, 31'h0};
    return {s, ex[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [31:0] r;
    int k;
    k = $urandom_range(0, 9);
    r = $urandom;
    case (k)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3, 4: e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    if (k == 1 && r[31]) r[22:0] = '0;
    return {r[30], e, r[22:0]};
  endfunction

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_latency();
    int n;
    @(posedge clk); #1;
    out_ready = 1; in_valid = 1; in_a = 32'h40000000; in_b = 32'h40400000; in_tag = 4'd3;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL latency_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    // Output handshake edge is n+1 edges after the accepting edge.
    checks++; if (n + 1 != 3) begin errors++; $display("FAIL latency_edges got %0d want 3", n + 1); end
    checks++; if (out_data !== 32'h40C00000 || out_tag !== 4'd3)
      begin errors++; $display("FAIL latency_result got %h/%0d want 40c00000/3", out_data, out_tag); end
    @(posedge clk); #1;
  endtask

  task automatic test_special_cases();
    logic [31:0] ta [15] = '{32'h3F800001, 32'h7F000000, 32'h00000000, 32'h80000000, 32'h00800000,
                             32'h7FC12345, 32'hFF800000, 32'h00000001, 32'hC0000000, 32'h3FFFFFFF,
                             32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800000, 32'h00800000, 32'hFF800000};
    logic [31:0] tb [15] = '{32'h3FC00001, 32'h7F000000, 32'h7F800000, 32'h3F800000, 32'h00800000,
                             32'h3F800000, 32'h40000000, 32'hBF800000, 32'hC0400000, 32'h3FFFFFFF,
                             32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F000000, 32'h80000000};
    logic [31:0] te [15] = '{RND_EXP,      32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h00000000,
                             32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h40C00000, 32'h407FFFFE,
                             32'h7F7FFFFF, 32'h7F800000, 32'h00800000, 32'h00000000, 32'h7FC00000};
    int n;
    out_ready = 1;
    for (int i = 0; i < 15; i++) begin
      in_a = ta[i]; in_b = tb[i]; in_tag = 4'(i); in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      n = 0;
      while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
      checks++;
      if (out_valid !== 1'b1 || out_data !== te[i] || out_tag !== 4'(i)) begin
        errors++;
        $display("FAIL special[%0d] %h*%h got v=%b %h tag %0d want %h tag %0d",
                 i, ta[i], tb[i], out_valid, out_data, out_tag, te[i], i);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    logic [35:0] q[$];
    logic [35:0] exp_v;
    logic [31:0] a, b;
    int sent, got, cyc;
    bit started;
    sent = 0; got = 0; cyc = 0; started = 0;
    out_ready = 1;
    while (got < N && cyc < N + 20) begin
      if (sent < N) begin
        a = rand_op(); b = rand_op();
        in_a = a; in_b = b; in_tag = 4'(sent); in_valid = 1;
      end else in_valid = 0;
      #1;
      if (in_valid && in_ready) begin q.push_back({4'(sent), ref_mul(a, b)}); sent++; end
      if (started) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble cycle %0d got out_valid %b want 1", cyc, out_valid); end
      end
      if (out_valid && out_ready) begin
        started = 1;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_extra got %h want nothing", out_data); end
        else begin
          exp_v = q.pop_front();
          if ({out_tag, out_data} !== exp_v) begin
            errors++;
            $display("FAIL b2b_result got %h tag %0d want %h tag %0d", out_data, out_tag, exp_v[31:0], exp_v[35:32]);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    checks++; if (got != N) begin errors++; $display("FAIL b2b_count got %0d want %0d", got, N); end
  endtask

  task automatic test_backpressure();
    localparam int N = 8;
    logic [35:0] q[$];
    logic [35:0] exp_v;
    logic [31:0] a, b, held_d;
    logic [3:0]  held_t;
    int sent, got, cyc;
    bit stalled;
    sent = 0; got = 0; cyc = 0; stalled = 0;
    while (got < N && cyc < 300) begin
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
          errors++;
          $display("FAIL bp_stable got v=%b %h tag %0d want 1 %h tag %0d", out_valid, out_data, out_tag, held_d, held_t);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < N) begin
        a = rand_op(); b = rand_op();
        in_a = a; in_b = b; in_tag = 4'(sent + 4); in_valid = 1;
      end else in_valid = 0;
      #1;
      stalled = out_valid && !out_ready;
      held_d = out_data; held_t = out_tag;
      if (in_valid && in_ready) begin q.push_back({4'(sent + 4), ref_mul(a, b)}); sent++; end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL bp_extra got %h want nothing", out_data); end
        else begin
          exp_v = q.pop_front();
          if ({out_tag, out_data} !== exp_v) begin
            errors++;
            $display("FAIL bp_result got %h tag %0d want %h tag %0d", out_data, out_tag, exp_v[31:0], exp_v[35:32]);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    checks++; if (got != N) begin errors++; $display("FAIL bp_count got %0d want %0d", got, N); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] a, b, exp_d;
    int n, ghosts;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_a = 32'h3F800000 + 32'(i); in_b = 32'h40000000; in_tag = 4'(9 + i); in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    rst = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0)
      begin errors++; $display("FAIL mid_rst_flush got v=%b %h want 0 0", out_valid, out_data); end
    rst = 0; out_ready = 1;
    a = 32'hC0A00000; b = 32'h3E800000; exp_d = ref_mul(a, b);
    in_a = a; in_b = b; in_tag = 4'hD; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_d || out_tag !== 4'hD)
      begin errors++; $display("FAIL mid_rst_new_op got v=%b %h tag %0d want %h tag 13", out_valid, out_data, out_tag, exp_d); end
    ghosts = 0;
    repeat (5) begin @(posedge clk); #1; if (out_valid) ghosts++; end
    checks++; if (ghosts != 0) begin errors++; $display("FAIL mid_rst_ghosts got %0d want 0", ghosts); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    clk = 0; rst = 1; in_valid = 0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 0;
    test_reset();
    test_latency();
    test_special_cases();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
